// File: rtl/sap_ctrl_pkg.sv
// Shared constants for the SAP-1 control sequencer: opcodes, T-state
// encoding and control-word bit positions.
package sap_ctrl_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_T1   = 3'd0,
    ST_T2   = 3'd1,
    ST_T3   = 3'd2,
    ST_T4   = 3'd3,
    ST_T5   = 3'd4,
    ST_T6   = 3'd5,
    ST_HALT = 3'd6
  } state_e;

  localparam int CW_W  = 13;
  localparam int CW_CP = 0;
  localparam int CW_EP = 1;
  localparam int CW_LP = 2;
  localparam int CW_LM = 3;
  localparam int CW_CE = 4;
  localparam int CW_LI = 5;
  localparam int CW_EI = 6;
  localparam int CW_LA = 7;
  localparam int CW_EA = 8;
  localparam int CW_SU = 9;
  localparam int CW_EU = 10;
  localparam int CW_LB = 11;
  localparam int CW_LO = 12;

  typedef logic [CW_W-1:0] cword_t;

  // Single-bit control word with only the strobe at index idx set.
  function automatic cword_t cw_bit(input int idx);
    return cword_t'(1) << idx;
  endfunction

  // One-hot T-state display; HALT (and any unused code) shows no T-state.
  function automatic logic [5:0] tstate_onehot(input state_e s);
    case (s)
      ST_T1:   return 6'b000001;
      ST_T2:   return 6'b000010;
      ST_T3:   return 6'b000100;
      ST_T4:   return 6'b001000;
      ST_T5:   return 6'b010000;
      ST_T6:   return 6'b100000;
      default: return 6'b000000;
    endcase
  endfunction

endpackage

// File: rtl/sap_microcode_rom.sv
// Combinational microcode: (opcode, T-state) -> control word plus flags
// marking the instruction's last T-state and the halt request.
module sap_microcode_rom
  import sap_ctrl_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  state_e     state_i,
  output cword_t     cw_o,
  output logic       last_o,
  output logic       halt_o
);

  // Decode table; each T-state drives at most one bus source.
  always_comb begin
    cw_o   = '0;
    last_o = 1'b0;
    halt_o = 1'b0;
    case (state_i)
      ST_T1: cw_o = cw_bit(CW_EP) | cw_bit(CW_LM);
      ST_T2: cw_o = cw_bit(CW_CP);
      ST_T3: cw_o = cw_bit(CW_CE) | cw_bit(CW_LI);
      ST_T4: begin
        case (opcode_i)
          OP_LDA, OP_ADD, OP_SUB: cw_o = cw_bit(CW_EI) | cw_bit(CW_LM);
          OP_JMP: begin
            cw_o   = cw_bit(CW_EI) | cw_bit(CW_LP);
            last_o = 1'b1;
          end
          OP_OUT: begin
            cw_o   = cw_bit(CW_EA) | cw_bit(CW_LO);
            last_o = 1'b1;
          end
          OP_HLT:  halt_o = 1'b1;
          default: last_o = 1'b1;
        endcase
      end
      ST_T5: begin
        case (opcode_i)
          OP_LDA: begin
            cw_o   = cw_bit(CW_CE) | cw_bit(CW_LA);
            last_o = 1'b1;
          end
          OP_ADD, OP_SUB: cw_o = cw_bit(CW_CE) | cw_bit(CW_LB);
          // Opcode changed mid-instruction: bail back to fetch quietly.
          default: last_o = 1'b1;
        endcase
      end
      ST_T6: begin
        last_o = 1'b1;
        case (opcode_i)
          OP_ADD:  cw_o = cw_bit(CW_EU) | cw_bit(CW_LA);
          OP_SUB:  cw_o = cw_bit(CW_EU) | cw_bit(CW_LA) | cw_bit(CW_SU);
          default: cw_o = '0;
        endcase
      end
      default: begin
        cw_o   = '0;
        last_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP-1 control sequencer: T1..T6 ring with free-run / single-step
// advance, HALT latch and advance-gated control strobes.
module sap_control_sequencer
  import sap_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] opcode,
  input  logic       run,
  input  logic       step,
  output logic       cp,
  output logic       ep,
  output logic       lp,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb,
  output logic       lo,
  output logic       hlt,
  output logic [5:0] t_state
);

  state_e state_q, state_d;
  logic   step_q, step_d;
  logic   step_rise;
  logic   advance;
  cword_t rom_cw;
  logic   rom_last;
  logic   rom_halt;
  cword_t cw;

  // One advance per step press; run overrides single-step.
  assign step_rise = step & ~step_q;
  assign advance   = run | step_rise;

  sap_microcode_rom u_rom (
    .opcode_i (opcode),
    .state_i  (state_q),
    .cw_o     (rom_cw),
    .last_o   (rom_last),
    .halt_o   (rom_halt)
  );

  // State and step-history registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_T1;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Next T-state: move only on advance; HALT is left only through clr.
  always_comb begin
    state_d = state_q;
    step_d  = step;
    if (state_q != ST_HALT && advance) begin
      if (rom_halt) begin
        state_d = ST_HALT;
      end else if (rom_last) begin
        state_d = ST_T1;
      end else begin
        case (state_q)
          ST_T1:   state_d = ST_T2;
          ST_T2:   state_d = ST_T3;
          ST_T3:   state_d = ST_T4;
          ST_T4:   state_d = ST_T5;
          ST_T5:   state_d = ST_T6;
          default: state_d = ST_T1;
        endcase
      end
    end
  end

  // Strobes fire only in an advancing cycle and never while clr is high.
  always_comb begin
    cw      = '0;
    hlt     = (state_q == ST_HALT) && !clr;
    t_state = tstate_onehot(state_q);
    if (!clr && state_q != ST_HALT && advance) begin
      cw = rom_cw;
    end
  end

  assign cp = cw[CW_CP];
  assign ep = cw[CW_EP];
  assign lp = cw[CW_LP];
  assign lm = cw[CW_LM];
  assign ce = cw[CW_CE];
  assign li = cw[CW_LI];
  assign ei = cw[CW_EI];
  assign la = cw[CW_LA];
  assign ea = cw[CW_EA];
  assign su = cw[CW_SU];
  assign eu = cw[CW_EU];
  assign lb = cw[CW_LB];
  assign lo = cw[CW_LO];

endmodule
